// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, MSB first.
// Produces {remainder, quotient} for the hi/lo muxes, a modulus output and a divide-by-zero flag.
module seq_divider #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y,
  output logic [WIDTH-1:0]   mod,
  output logic               dbz
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               accept;

  // Since rem < divisor always holds, the WIDTH+1 bit trial's MSB is a true sign bit.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, div_q};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    y_d     = y_q;
    mod_d   = mod_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          quo_d   = a;
          div_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (b == '0);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (dz_q) begin
          y_d     = {quo_q, ALL_ONES};
          mod_d   = quo_q;
          dbz_d   = 1'b1;
          dz_d    = 1'b0;
          state_d = DONE;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            y_d     = {rem_next, quo_next};
            mod_d   = rem_next;
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      y_q     <= '0;
      mod_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      y_q     <= y_d;
      mod_q   <= mod_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign y    = y_q;
  assign mod  = mod_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge monitor pops on done.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        busy, done, dbz;
  logic [31:0] y;
  logic [15:0] mod;

  seq_divider #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .y(y), .mod(mod), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic [15:0] m;
    logic        d;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  logic [31:0] last_y = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 0) begin
      e.y = {a, 16'hFFFF};
      e.m = a;
      e.d = 1'b1;
    end else begin
      e.y = {16'(a % b), 16'(a / b)};
      e.m = 16'(a % b);
      e.d = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compares every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) begin
        tests++;
        fails++;
        $display("FAIL busy_done_excl: got busy=1 done=1 expected not both");
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done with y=%0h expected none", y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("y", 64'(y), 64'(e.y));
          chk("mod", 64'(mod), 64'(e.m));
          chk("dbz", 64'(dbz), 64'(e.d));
          last_y = e.y;
        end
      end
    end
  end

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt <= prev && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt <= prev) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input exp_t e, input int lat);
    int c0, p;
    @(negedge clk);
    start = 1'b1;
    a_i = a;
    b_i = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    c0 = cyc;
    p = done_cnt;
    start = 1'b0;
    a_i = 16'($urandom);
    b_i = 16'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("y_hold", 64'(y), 64'(last_y));
    wait_done(p);
    chk("latency", 64'(last_done_cyc - c0), 64'(lat));
  endtask

  initial begin
    int c0, p, d1;
    exp_t e;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_mod", 64'(mod), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(16'd100, 16'd7, '{32'h0002000E, 16'h0002, 1'b0}, 16);
    run_op(16'h1234, 16'd0, '{32'h1234FFFF, 16'h1234, 1'b1}, 1);
    run_op(16'd9, 16'd3, '{32'h00000003, 16'h0000, 1'b0}, 16);
    run_op(16'hFFFF, 16'd1, '{32'h0000FFFF, 16'h0000, 1'b0}, 16);
    run_op(16'd5, 16'hFFFF, '{32'h00050000, 16'h0005, 1'b0}, 16);

    // start during RUN must be ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a_i = 16'd50; b_i = 16'd5;
    sb.push_back('{32'h0000000A, 16'h0000, 1'b0});
    @(posedge clk);
    #1;
    c0 = cyc; p = done_cnt; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a_i = 16'd9; b_i = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0; a_i = 16'hAAAA; b_i = 16'h0003;
    chk("busy_mid_run", 64'(busy), 64'd1);
    wait_done(p);
    chk("mid_latency", 64'(last_done_cyc - c0), 64'd16);
    repeat (20) @(posedge clk);
    chk("single_done", 64'(done_cnt), 64'(p + 1));

    // back-to-back with start held through DONE
    @(negedge clk);
    start = 1'b1; a_i = 16'd17; b_i = 16'd4;
    sb.push_back('{32'h00010004, 16'h0001, 1'b0});
    @(posedge clk);
    #1;
    c0 = cyc; p = done_cnt; b_i = 16'd5;
    sb.push_back('{32'h00020003, 16'h0002, 1'b0});
    wait_done(p);
    d1 = last_done_cyc;
    #1;
    start = 1'b0;
    p = done_cnt;
    wait_done(p);
    chk("b2b_first_lat", 64'(d1 - c0), 64'd16);
    chk("b2b_spacing", 64'(last_done_cyc - d1), 64'd17);

    // asynchronous reset mid-operation
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a_i = 16'd1000; b_i = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0; p = done_cnt;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_y", 64'(y), 64'd0);
    chk("arst_mod", 64'(mod), 64'd0);
    chk("arst_dbz", 64'(dbz), 64'd0);
    last_y = '0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("no_done_after_arst", 64'(done_cnt), 64'(p));
    run_op(16'd1000, 16'd3, '{32'h0001014D, 16'h0001, 1'b0}, 16);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      int sel;
      ra = 16'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = 16'd0;
      else if (sel < 3)  rb = 16'($urandom_range(1, 15));
      else if (sel == 3) rb = ra;
      else               rb = 16'($urandom);
      e = model(ra, rb);
      run_op(ra, rb, e, (rb == 0) ? 1 : 16);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider that replaces the combinational divide unit in front of the hi/lo special-purpose registers. It takes the two register-file read outputs as dividend and divisor and produces a packed {remainder, quotient} result for the hi/lo input muxes plus a separate modulus output. It asserts a one-cycle hi/lo write strobe when the result is ready, and exposes busy so the control unit can stall the PC.

Parameters:
WIDTH, 16, operand width; matches the datapath word.
CNT_W, 5, iteration counter width; must hold WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a division; sampled only in IDLE or DONE.
a  input  WIDTH  dividend (register-file read output 1).
b  input  WIDTH  divisor (register-file read output 2).
busy  output  1  high while an operation is in progress (RUN).
done  output  1  one-cycle pulse when the result is valid; also the hi/lo write enable.
y  output  2*WIDTH  {remainder, quotient}; [2W-1:W] feeds the hi mux, [W-1:0] feeds the lo mux.
mod  output  WIDTH  remainder; feeds the mod mux.
dbz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done and dbz are 0; y=0; mod=0; internal dividend, divisor, partial remainder and count cleared. Reset takes effect immediately, including mid-operation. There is no partial result and no done pulse.
- States: IDLE, RUN, DONE.
- IDLE with start=1 at edge E0, b!=0:
  - latch a into the quotient shift register and b into the divisor; partial remainder=0; count=0.
  - move to RUN; busy=1 from E0.
- IDLE with start=1 at edge E0, b==0:
  - move to RUN with a divide-by-zero marker.
  - at E1: quotient=all ones, remainder=a, dbz=1; go to DONE with done=1.
  - total latency is 1 cycle.
- RUN, each edge (one quotient bit per cycle, MSB first):
  - shift {rem, q} left by 1.
  - trial = rem_shifted - divisor, computed WIDTH+1 bits wide.
  - if trial is non-negative: rem=trial, q[0]=1; else keep rem, q[0]=0.
  - count increments.
- At edge E16 (the WIDTH-th iteration): y={rem, q}, mod=rem, dbz=0; go to DONE with done=1 and busy=0.
  - Normal latency: start sampled at E0, result and done valid after E16.
- DONE (exactly one cycle):
  - start=1 is accepted as in IDLE (back-to-back operation; done is still 1 during this cycle).
  - start=0 goes to IDLE.
  - done returns to 0 at the next edge either way.
- y, mod and dbz hold their values until the next completion or reset. The next start does not clear them.
- start while in RUN is ignored. The operation in flight is unaffected and a/b changes are not sampled.
- a and b are sampled only at the accepting edge. Operand changes during RUN have no effect.
- Arithmetic is unsigned only. Result range: quotient <= a, remainder < b when b!=0.
- busy and done are never high together.

Test Plan:
- a=100, b=7, start for 1 cycle -> busy for 16 cycles; then done=1 for 1 cycle with y=0x0002000E, mod=0x0002, dbz=0.
- a=0x1234, b=0 -> done 1 cycle after start; y=0x1234FFFF, mod=0x1234, dbz=1. A following 9/3 run then gives y=0x00000003 and dbz=0.
- a=0xFFFF, b=1 -> y=0x0000FFFF. Then a=5, b=0xFFFF -> y=0x00050000. Both complete in 16 cycles.
- a=50, b=5 started; at cycle 4 of RUN assert start with a=9, b=2 and change a/b -> result is still y=0x0000000A, busy stays high for 16 cycles, and exactly one done pulse occurs.
- Back-to-back: start held high through DONE with a=17, b=4, then a=17, b=5 -> two done pulses 17 cycles apart; y=0x00010004, then y=0x00020003.
- Drop rst_n at RUN cycle 8 of 1000/3 -> busy, done, y and mod go to 0 immediately; no done pulse. After release, 1000/3 gives y=0x0001014D.
